// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data memory.
// master = requester/memory side, slave = arbiter side.
interface data_mem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic [15:0] r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ack;
  logic        r0_err;
  logic [15:0] r0_rdata;

  logic        r1_req;
  logic        r1_we;
  logic [15:0] r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ack;
  logic        r1_err;
  logic [15:0] r1_rdata;

  logic [15:0] mem_addra;
  logic [15:0] mem_din;
  logic        mem_wea;
  logic [15:0] mem_addrb;
  logic [15:0] mem_dout;

  logic        busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_dout,
    output r0_ack, r0_err, r0_rdata,
    output r1_ack, r1_err, r1_rdata,
    output mem_addra, mem_din, mem_wea, mem_addrb,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_dout,
    input  r0_ack, r0_err, r0_rdata,
    input  r1_ack, r1_err, r1_rdata,
    input  mem_addra, mem_din, mem_wea, mem_addrb,
    input  busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter: fixed priority to r0 with a starvation limit for r1,
// one access per three cycles, all memory-side and response outputs registered.
//
// state  | meaning
// IDLE   | waiting; winner's request latched on the edge leaving this state
// ACCESS | memory port driven with the latched access
// RESP   | granted requester sees ack (and err) for one cycle
module data_mem_arbiter #(
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [16:0]   DEPTH_LIM  = 17'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gnt1;
  logic            r_we;
  logic            r_in_range;
  logic [15:0]     r_wdata;
  logic [CW-1:0]   r_starve_cnt;

  logic            w_any_req;
  logic            w_gnt1;
  logic            w_we;
  logic [15:0]     w_addr;
  logic [15:0]     w_wdata;
  logic            w_in_range;
  logic [15:0]     w_cap;

  // r1 overrides r0 only once r0 has taken STARVE_MAX grants in a row while r1 waited
  always_comb begin
    w_any_req  = bus.r0_req | bus.r1_req;
    w_gnt1     = bus.r1_req & (~bus.r0_req | (r_starve_cnt == STARVE_LIM));
    w_we       = w_gnt1 ? bus.r1_we    : bus.r0_we;
    w_addr     = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
    w_wdata    = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
    w_in_range = ({1'b0, w_addr} < DEPTH_LIM);
  end

  always_comb begin
    w_cap = 16'h0000;
    if (r_in_range) begin
      w_cap = r_we ? r_wdata : bus.mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy = (r_state != S_IDLE);

  // Memory port values are loaded one edge ahead so they are flop outputs throughout ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt1        <= 1'b0;
      r_we          <= 1'b0;
      r_in_range    <= 1'b0;
      r_wdata       <= 16'h0000;
      r_starve_cnt  <= '0;
      bus.mem_addra <= 16'h0000;
      bus.mem_addrb <= 16'h0000;
      bus.mem_din   <= 16'h0000;
      bus.mem_wea   <= 1'b0;
      bus.r0_ack    <= 1'b0;
      bus.r0_err    <= 1'b0;
      bus.r0_rdata  <= 16'h0000;
      bus.r1_ack    <= 1'b0;
      bus.r1_err    <= 1'b0;
      bus.r1_rdata  <= 16'h0000;
    end else begin
      bus.mem_addra <= 16'h0000;
      bus.mem_addrb <= 16'h0000;
      bus.mem_din   <= 16'h0000;
      bus.mem_wea   <= 1'b0;
      bus.r0_ack    <= 1'b0;
      bus.r0_err    <= 1'b0;
      bus.r1_ack    <= 1'b0;
      bus.r1_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt1        <= w_gnt1;
            r_we          <= w_we;
            r_in_range    <= w_in_range;
            r_wdata       <= w_wdata;
            bus.mem_addra <= w_addr;
            bus.mem_addrb <= w_addr;
            bus.mem_din   <= w_wdata;
            bus.mem_wea   <= w_we & w_in_range;
            if (w_gnt1) begin
              r_starve_cnt <= '0;
            end else if (bus.r1_req && (r_starve_cnt != STARVE_LIM)) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (r_gnt1) begin
            bus.r1_ack   <= 1'b1;
            bus.r1_err   <= ~r_in_range;
            bus.r1_rdata <= w_cap;
          end else begin
            bus.r0_ack   <= 1'b1;
            bus.r0_err   <= ~r_in_range;
            bus.r0_rdata <= w_cap;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: 64-word memory model, hand-computed expectations.
module tb_data_mem_arbiter;
  logic clk;
  logic rst_n;
  logic init_mem;
  int   n_chk;
  int   n_err;
  int   wea_total;

  data_mem_arbiter_if bus ();

  data_mem_arbiter #(.DEPTH(64), .STARVE_MAX(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:63];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (bus.mem_wea && (bus.mem_addra < 16'd64)) begin
      mem[bus.mem_addra[5:0]] <= bus.mem_din;
    end
  end

  assign bus.mem_dout = (bus.mem_addrb < 16'd64) ? mem[bus.mem_addrb[5:0]] : 16'h0000;

  always @(posedge clk) if (bus.mem_wea) wea_total++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One access from requester `who`; returns captured rdata, err, edges to ack and write strobes seen.
  task automatic access(input bit who, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic err, output int lat, output int wea);
    int w0;
    @(negedge clk);
    w0 = wea_total;
    if (who) begin
      bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd;
    end else begin
      bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd;
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(who ? bus.r1_ack : bus.r0_ack) && lat < 8);
    rd  = who ? bus.r1_rdata : bus.r0_rdata;
    err = who ? bus.r1_err   : bus.r0_err;
    if (who) bus.r1_req = 1'b0; else bus.r0_req = 1'b0;
    @(posedge clk); #1;
    wea = wea_total - w0;
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  int          wea;
  logic [9:0]  gseq;
  int          budget;

  initial begin
    n_chk = 0; n_err = 0; wea_total = 0;
    init_mem = 1'b1;
    rst_n = 1'b0;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_acks",  32'({bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err}), 0);
    chk("rst_rdata", 32'({bus.r0_rdata, bus.r1_rdata}), 0);
    chk("rst_mem",   32'({bus.mem_wea, bus.mem_addra, bus.mem_din}), 0);
    @(negedge clk);
    rst_n = 1'b1; init_mem = 1'b0;

    // write then read addr 5
    access(0, 1, 16'd5, 16'hBEEF, rd, er, lat, wea);
    chk("wr5_lat", 32'(lat), 2);
    chk("wr5_wea", 32'(wea), 1);
    chk("wr5_err", 32'(er), 0);
    chk("wr5_rd",  32'(rd), 32'hBEEF);
    chk("wr5_mem", 32'(mem[5]), 32'hBEEF);
    chk("ack_pulse", 32'(bus.r0_ack), 0);
    access(0, 0, 16'd5, 16'h0000, rd, er, lat, wea);
    chk("rd5_lat", 32'(lat), 2);
    chk("rd5_wea", 32'(wea), 0);
    chk("rd5_err", 32'(er), 0);
    chk("rd5_rd",  32'(rd), 32'hBEEF);

    // out-of-range write, boundary reads
    access(1, 1, 16'd64, 16'h1234, rd, er, lat, wea);
    chk("oor_wea", 32'(wea), 0);
    chk("oor_err", 32'(er), 1);
    chk("oor_rd",  32'(rd), 0);
    access(1, 0, 16'd0, 16'h0000, rd, er, lat, wea);
    chk("rd0_rd",  32'(rd), 32'hA000);
    chk("rd0_err", 32'(er), 0);
    access(1, 0, 16'd63, 16'h0000, rd, er, lat, wea);
    chk("rd63_rd",  32'(rd), 32'hA03F);
    chk("rd63_err", 32'(er), 0);
    access(1, 0, 16'hFFFF, 16'h0000, rd, er, lat, wea);
    chk("rdffff_rd",  32'(rd), 0);
    chk("rdffff_err", 32'(er), 1);
    chk("r0_hold", 32'(bus.r0_rdata), 32'hBEEF);

    // both requesting continuously: starvation limit 4
    @(negedge clk);
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 16'd1;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 16'd2;
    for (int i = 0; i < 10; i++) begin
      budget = 0;
      do begin
        @(posedge clk); #1; budget++;
      end while (!(bus.r0_ack || bus.r1_ack) && budget < 8);
      gseq[i] = bus.r1_ack;
    end
    bus.r0_req = 0; bus.r1_req = 0;
    chk("grant_seq", 32'(gseq), 32'b1000010000);
    chk("gs_r0_rd",  32'(bus.r0_rdata), 32'hA001);
    chk("gs_r1_rd",  32'(bus.r1_rdata), 32'hA002);
    @(posedge clk); #1;

    // back-to-back r1 with req held through ack
    access(0, 0, 16'd5, 16'h0000, rd, er, lat, wea);
    chk("pre_b2b_rd", 32'(rd), 32'hBEEF);
    @(negedge clk);
    bus.r1_req = 1; bus.r1_we = 1; bus.r1_addr = 16'd10; bus.r1_wdata = 16'h1111;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.r1_ack && lat < 8);
    chk("b2b1_lat", 32'(lat), 2);
    chk("b2b1_rd",  32'(bus.r1_rdata), 32'h1111);
    bus.r1_addr = 16'd11; bus.r1_wdata = 16'h2222;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) chk("b2b_ack_low", 32'(bus.r1_ack), 0);
    end while (!bus.r1_ack && lat < 8);
    bus.r1_req = 0;
    chk("b2b2_lat", 32'(lat), 3);
    chk("b2b2_rd",  32'(bus.r1_rdata), 32'h2222);
    chk("b2b_r0",   32'(bus.r0_rdata), 32'hBEEF);
    @(posedge clk); #1;
    chk("b2b_mem10", 32'(mem[10]), 32'h1111);
    chk("b2b_mem11", 32'(mem[11]), 32'h2222);

    // reset during ACCESS of an r0 write
    @(negedge clk);
    bus.r0_req = 1; bus.r0_we = 1; bus.r0_addr = 16'd20; bus.r0_wdata = 16'h5555;
    @(posedge clk); #1;
    chk("mr_busy_acc", 32'(bus.busy), 1);
    chk("mr_wea_acc",  32'(bus.mem_wea), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_wea_drop", 32'(bus.mem_wea), 0);
    chk("mr_busy",     32'(bus.busy), 0);
    chk("mr_ack",      32'(bus.r0_ack), 0);
    chk("mr_r0_rd",    32'(bus.r0_rdata), 0);
    bus.r0_req = 0;
    @(posedge clk); #1;
    chk("mr_mem20", 32'(mem[20]), 32'hA014);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 16'd20, 16'h0000, rd, er, lat, wea);
    chk("mr_r1_lat", 32'(lat), 2);
    chk("mr_r1_rd",  32'(rd), 32'hA014);
    chk("mr_r0_ack", 32'(bus.r0_ack), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
